// File: rtl/job_seq_pkg.sv
// Shared types and widths for the job sequencer: FSM state encoding,
// operand/result field widths and the packed job record held in the FIFO.
package job_seq_pkg;

  localparam int X_W  = 8;   // job operand width (also core result y width)
  localparam int ON_W = 2;   // job mode width
  localparam int S_W  = 3;   // core shift-count result width
  localparam int Y_W  = X_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    WAIT_ACT = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]  x;
    logic [ON_W-1:0] on;
  } job_t;

  localparam int JOB_W = $bits(job_t);

  // Build a job record from its two fields.
  function automatic job_t make_job(input logic [X_W-1:0] jx, input logic [ON_W-1:0] jon);
    job_t j;
    j.x  = jx;
    j.on = jon;
    return j;
  endfunction

endpackage

// File: rtl/job_sequencer_if.sv
// Job input stream and result output stream of the job sequencer.
//
// Handshake rule (both streams): a transfer happens at a rising edge where
// valid and ready are both 1. Once the source raises valid it keeps valid
// and the payload stable until that transfer; ready may change freely.
interface job_sequencer_if;
  import job_seq_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [X_W-1:0]  in_x;
  logic [ON_W-1:0] in_on;

  logic            out_valid;
  logic            out_ready;
  logic [Y_W-1:0]  out_y;
  logic [S_W-1:0]  out_s;
  logic            out_b;
  logic            out_err;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, in_x, in_on, out_ready,
    input  in_ready, out_valid, out_y, out_s, out_b, out_err
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_x, in_on, out_ready,
    output in_ready, out_valid, out_y, out_s, out_b, out_err
  );

endinterface

// File: rtl/job_fifo.sv
// Small synchronous job FIFO. DEPTH must be a power of two so the read and
// write pointers wrap naturally; the occupancy counter has one extra bit so
// that full and empty are unambiguous. Pushes into a full FIFO and pops from
// an empty one are ignored. The head entry is visible on dout (show-ahead).
module job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/job_sequencer.sv
// Job sequencer: buffers operand jobs in a FIFO, launches them one at a time
// into the shift-count core (start pulse, x/on held while it runs), captures
// y/s/b when the core drops active and offers the result downstream.
//
// Optional feature macro: JOB_SEQUENCER_TIMEOUT_EN. When defined, a cycle
// counter bounds the time spent in WAIT_ACT+RUN to TIMEOUT cycles and a
// timed-out job completes with out_err=1 and zeroed data. When undefined the
// sequencer waits on the core indefinitely and out_err is constant 0.
module job_sequencer
  import job_seq_pkg::*;
#(
  parameter int DEPTH = 4
`ifdef JOB_SEQUENCER_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic            clk,
  input  logic            rst,
  job_sequencer_if.slave  bus,
  output logic [X_W-1:0]  x,
  output logic [ON_W-1:0] on,
  output logic            start,
  input  logic            active,
  input  logic [Y_W-1:0]  y,
  input  logic [S_W-1:0]  s,
  input  logic            b,
  output logic            busy,
  output state_t          dbg_state
);

  state_t                 state;
  state_t                 state_nxt;
  job_t                   head;
  job_t                   job_in;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   push;
  logic                   pop;
  logic                   load_job;
  logic                   capture;

  // in_ready is gated by rst so nothing is accepted while reset is held.
  assign bus.in_ready = rst && !fifo_full;
  assign push         = bus.in_valid && bus.in_ready;
  assign job_in       = make_job(bus.in_x, bus.in_on);

  job_fifo #(
    .DEPTH (DEPTH),
    .W     (JOB_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (job_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef JOB_SEQUENCER_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;

  // Cycles spent waiting on the core; cleared while launching a job.
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state == LAUNCH) begin
      to_cnt <= '0;
    end else if ((state == WAIT_ACT) || (state == RUN)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode. A pop always coincides with entering
  // LAUNCH, so the head is latched into x/on on that same edge.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_job  = 1'b0;
    capture   = 1'b0;
    start     = 1'b0;
`ifdef JOB_SEQUENCER_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          load_job  = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        start     = 1'b1;
        state_nxt = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (active) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!active) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            load_job  = 1'b1;
            state_nxt = LAUNCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef JOB_SEQUENCER_TIMEOUT_EN
    // A genuine completion in RUN wins over a timeout on the same cycle.
    if (((state == WAIT_ACT) || ((state == RUN) && active)) && (to_cnt == TO_LAST)) begin
      timeout_hit = 1'b1;
      state_nxt   = DONE;
    end
`endif
  end

  // Operand registers driving the core; only a launch changes them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x  <= '0;
      on <= '0;
    end else if (load_job) begin
      x  <= head.x;
      on <= head.on;
    end
  end

  // Result registers; only written on the transition into DONE, so they are
  // stable for as long as out_valid is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.out_y <= '0;
      bus.out_s <= '0;
      bus.out_b <= 1'b0;
    end else if (capture) begin
      bus.out_y <= y;
      bus.out_s <= s;
      bus.out_b <= b;
`ifdef JOB_SEQUENCER_TIMEOUT_EN
    end else if (timeout_hit) begin
      bus.out_y <= '0;
      bus.out_s <= '0;
      bus.out_b <= 1'b0;
`endif
    end
  end

`ifdef JOB_SEQUENCER_TIMEOUT_EN
  // Error flag: set by a timeout, cleared by a normal completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.out_err <= 1'b0;
    end else if (capture) begin
      bus.out_err <= 1'b0;
    end else if (timeout_hit) begin
      bus.out_err <= 1'b1;
    end
  end
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.out_valid = (state == DONE);
  assign busy          = (state != IDLE) || (fifo_count != '0);
  assign dbg_state     = state;

endmodule

// File: tb/tb_job_sequencer.sv
// Self-checking bench for job_sequencer: reset values, a table of single
// jobs with hand-computed results, FIFO fill/order, result backpressure,
// reset in the middle of a job and (with JOB_SEQUENCER_TIMEOUT_EN) timeout.
module tb_job_sequencer;
  import job_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [X_W-1:0]  x;
  logic [ON_W-1:0] on;
  logic            start;
  logic            active = 1'b0;
  logic [7:0]      y = 8'h00;
  logic [2:0]      s = 3'd0;
  logic            b = 1'b0;
  logic            busy;
  state_t          dbg_state;

  job_sequencer_if bus();

  job_sequencer #(
    .DEPTH (4)
`ifdef JOB_SEQUENCER_TIMEOUT_EN
    ,
    .TIMEOUT (16)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .x         (x),
    .on        (on),
    .start     (start),
    .active    (active),
    .y         (y),
    .s         (s),
    .b         (b),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Core behaviour: y = x ^ 0x99, s = x[2:0], b = on[1].
  function automatic logic [11:0] core_fn(input logic [7:0] jx, input logic [1:0] jo);
    return {jx ^ 8'h99, jx[2:0], jo[1]};
  endfunction

  // ---------------- core model ----------------
  // Sees start on the falling edge, raises active for core_len cycles
  // (core_len >= 2) unless stalled; a stalled launch stays pending.
  int core_len   = 2;
  bit core_stall = 1'b0;
  bit pending    = 1'b0;
  int core_cnt   = 0;

  always @(negedge clk) begin
    if (start) pending = 1'b1;
    if (active) begin
      core_cnt--;
      if (core_cnt == 0) active = 1'b0;
    end else if (pending && !core_stall) begin
      pending  = 1'b0;
      active   = 1'b1;
      core_cnt = core_len;
      {y, s, b} = core_fn(x, on);
    end
  end

  // ---------------- start / operand monitor ----------------
  int         start_cnt = 0;
  int         x_bad     = 0;
  bit         track     = 1'b0;
  logic [9:0] launch_job;

  always @(negedge clk) begin
    if (!rst) begin
      track = 1'b0;
    end else if (start) begin
      start_cnt++;
      track      = 1'b1;
      launch_job = {x, on};
    end else if (track && active && ({x, on} != launch_job)) begin
      x_bad++;
    end
  end

  // ---------------- driver tasks ----------------
  // Called on a falling edge; returns on a falling edge.
  task automatic push_job(input logic [7:0] jx, input logic [1:0] jo);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = jx;
    bus.in_on    = jo;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready 0 after %0d cycles, expected 1", n);
    end else begin
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  // Waits for out_valid, samples the result, then accepts it.
  task automatic wait_result(output logic [12:0] got, output bit ok);
    int n = 0;
    while (!bus.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok  = bus.out_valid;
    got = {bus.out_y, bus.out_s, bus.out_b, bus.out_err};
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: out_valid 0 after %0d cycles, expected 1", n);
    end else begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] x;
    logic [1:0] on;
    int         run_len;
    logic [7:0] exp_y;
    logic [2:0] exp_s;
    logic       exp_b;
  } vec_t;

  vec_t tbl[5];

  // ---------------- main sequence ----------------
  logic [12:0] got;
  logic [12:0] held;
  bit          ok;
  int          sc0;
  int          bad;
  int          n;
  logic [7:0]  jx;
  logic [1:0]  jo;

  initial begin
    tbl[0] = '{8'hA5, 2'd2, 4, 8'h3C, 3'd5, 1'b1};
    tbl[1] = '{8'h00, 2'd0, 2, 8'h99, 3'd0, 1'b0};
    tbl[2] = '{8'hFF, 2'd3, 3, 8'h66, 3'd7, 1'b1};
    tbl[3] = '{8'h5A, 2'd1, 6, 8'hC3, 3'd2, 1'b0};
    tbl[4] = '{8'h81, 2'd2, 2, 8'h18, 3'd1, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_on     = '0;
    bus.out_ready = 1'b0;

    // Reset held low for two edges.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_x", 32'(x), 32'h0);
    check("rst_on", 32'(on), 32'h0);
    check("rst_start", 32'(start), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_fields", 32'({bus.out_y, bus.out_s, bus.out_b, bus.out_err}), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'h1);
    check("rel_busy", 32'(busy), 32'h0);
    @(negedge clk);

    // Single jobs from the table.
    for (int i = 0; i < 5; i++) begin
      sc0      = start_cnt;
      core_len = tbl[i].run_len;
      push_job(tbl[i].x, tbl[i].on);
      wait_result(got, ok);
      if (ok) check($sformatf("vec%0d_result", i), 32'(got),
                    32'({tbl[i].exp_y, tbl[i].exp_s, tbl[i].exp_b, 1'b0}));
      check($sformatf("vec%0d_starts", i), 32'(start_cnt - sc0), 32'h1);
    end
    check("idle_busy", 32'(busy), 32'h0);

    // Fill: first job stalls in WAIT_ACT, four more fill the FIFO.
    core_stall = 1'b1;
    core_len   = 2;
    for (int i = 0; i < 5; i++) begin
      jx = 8'h20 + 8'(i * 17);
      jo = 2'(i);
      push_job(jx, jo);
      exp_q.push_back({core_fn(jx, jo), 1'b0});
    end
    check("fill_in_ready", 32'(bus.in_ready), 32'h0);
    check("fill_busy", 32'(busy), 32'h1);
    core_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_result(got, ok);
      if (ok) check($sformatf("fill_order%0d", i), 32'(got), 32'(exp_q.pop_front()));
    end
    check("fill_in_ready_after", 32'(bus.in_ready), 32'h1);

    // Backpressure: result held for 10 cycles with a job queued behind it.
    core_len = 3;
    push_job(8'h12, 2'd0);
    exp_q.push_back({core_fn(8'h12, 2'd0), 1'b0});
    push_job(8'h34, 2'd3);
    exp_q.push_back({core_fn(8'h34, 2'd3), 1'b0});
    n = 0;
    while (!bus.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", 32'(bus.out_valid), 32'h1);
    held = {bus.out_y, bus.out_s, bus.out_b, bus.out_err};
    bad  = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.out_valid || start ||
          ({bus.out_y, bus.out_s, bus.out_b, bus.out_err} != held)) bad++;
    end
    check("bp_hold", 32'(bad), 32'h0);
    check("bp_first", 32'(held), 32'({8'h8B, 3'd2, 1'b0, 1'b0}));
    void'(exp_q.pop_front());
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_next_start", 32'(start), 32'h1);
    check("bp_valid_drop", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    wait_result(got, ok);
    if (ok) check("bp_second", 32'(got), 32'(exp_q.pop_front()));

`ifdef JOB_SEQUENCER_TIMEOUT_EN
    // Timeout: core never answers; result 16 cycles after leaving LAUNCH.
    core_stall = 1'b1;
    push_job(8'h55, 2'd2);
    n = 0;
    while (!start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("to_start_seen", 32'(start), 32'h1);
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!bus.out_valid && n < 100);
    check("to_cycles", 32'(n), 32'd16);
    check("to_result", 32'({bus.out_y, bus.out_s, bus.out_b, bus.out_err}), 32'h1);
    pending    = 1'b0;
    core_stall = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
`endif

    // Reset in the middle of a long job.
    core_len = 20;
    push_job(8'h77, 2'd1);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_x", 32'({x, on}), 32'h0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_in_ready", 32'(bus.in_ready), 32'h1);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid || start) bad++;
    end
    check("mid_rst_no_result", 32'(bad), 32'h0);
    n = 0;
    while (active && n < 100) begin
      @(negedge clk);
      n++;
    end
    core_len = 3;
    push_job(8'h3B, 2'd1);
    wait_result(got, ok);
    if (ok) check("post_rst_job", 32'(got), 32'({8'hA2, 3'd3, 1'b0, 1'b0}));
    check("post_rst_busy", 32'(busy), 32'h0);

    check("x_stable", 32'(x_bad), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
